rat_recovery_sequencer: RTL
===========================

Name: rat_recovery_sequencer

Overview:
- Sequences front-end rename state recovery after a pipeline flush (branch mispredict or exception).
- Sits beside retire/commit: walks the retirement RAT (RRAT) a group of lanes per cycle and copies each committed mapping into the front-end RAT.
- Accumulates the set of committed physical registers, then reloads the free list with its complement.
- Holds rename and retire stalled until recovery is complete.

Parameters:
- NUM_ARCH_REGS, 35, architectural registers mapped by the RATs.
- NUM_PHYS_REGS, 64, physical registers; LOG_PHYS = $clog2(NUM_PHYS_REGS).
- LANES, 4, RRAT entries copied per cycle; legal range 1..NUM_ARCH_REGS.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- flush_req  in  1  one-cycle pulse; start (or restart) recovery.
- rrat_rd_idx  out  LANES*$clog2(NUM_ARCH_REGS)  RRAT read addresses; lane i is bits [i*W +: W].
- rrat_rd_data  in  LANES*LOG_PHYS  RRAT read data, combinational, same cycle as rrat_rd_idx.
- frat_wr_en  out  LANES  per-lane front-end RAT write enable.
- frat_wr_idx  out  LANES*$clog2(NUM_ARCH_REGS)  front-end RAT write address (equals rrat_rd_idx).
- frat_wr_data  out  LANES*LOG_PHYS  front-end RAT write data (equals rrat_rd_data).
- fl_load  out  1  one-cycle pulse; free list replaces its contents with fl_load_mask.
- fl_load_mask  out  NUM_PHYS_REGS  bit p = 1 means physical register p is free.
- busy  out  1  stall rename and retire; RRAT is frozen while high.
- done  out  1  one-cycle pulse when recovery completes.
- perf_flushes  out  32  recovery count (optional feature).
- perf_stall_cycles  out  32  cycles with busy high (optional feature).

Behaviour:
- FSM states: IDLE, COPY, LOAD.
- Reset values:
  - State IDLE, base index 0, used mask 0.
  - All outputs 0.
- IDLE:
  - frat_wr_en = 0, busy = 0.
  - flush_req at edge k: go to COPY, base = 0, used = 0; busy rises in cycle k+1.
- COPY:
  - Lane i addresses base+i.
  - Lane i is enabled iff base+i < NUM_ARCH_REGS; disabled lanes drive idx 0 and data 0, and frat_wr_en[i] = 0.
  - Each enabled lane ORs bit rrat_rd_data[i] into the used mask; the cycle's own writes are included.
  - base += LANES each cycle.
  - When base+LANES >= NUM_ARCH_REGS, the next state is LOAD.
  - COPY lasts ceil(NUM_ARCH_REGS/LANES) cycles.
- LOAD (one cycle):
  - fl_load = 1, fl_load_mask = ~used (registered used mask, final group included).
  - done = 1, busy = 1.
  - Next state IDLE.
- Latency: flush at edge k gives COPY in cycles k+1..k+C and LOAD/done at k+C+1, where C = ceil(NUM_ARCH_REGS/LANES). With defaults, busy spans k+1..k+10 and done is at k+10.
- busy = (state != IDLE).
- flush_req while in COPY or LOAD:
  - Restart: the next cycle is COPY with base 0 and used cleared.
  - fl_load and done of the aborted pass are still driven in that LOAD cycle only if the state was LOAD; the free list is reloaded again at the end of the new pass.
- Duplicate physical tags in the RRAT are not detected; the mask is a plain OR.
- RESET mid-operation forces IDLE immediately; no fl_load or done is produced.
- Arithmetic: base is $clog2(NUM_ARCH_REGS+LANES) bits wide; lane index compares use that width, so there is no wrap.

Optional Feature:
- Macro RAT_RECOVERY_PERF_EN.
- Defined:
  - perf_flushes increments on each flush_req accepted, including restarts.
  - perf_stall_cycles increments every cycle busy = 1.
  - Both are 32-bit wrapping counters, cleared by RESET.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package/header holds:
  - LOG_PHYS and LOG_ARCH width macros.
  - FSM state encodings (IDLE=2'd0, COPY=2'd1, LOAD=2'd2).
  - NUM_ARCH_REGS default 35, shared with the RAT and RRAT instances.
- One natural sub-module: recovery_used_mask, which takes LANES physical tags plus per-lane enables, clear, and accumulate, and returns the registered NUM_PHYS_REGS used mask.

Test Plan:
- Identity RRAT (entry i = i), defaults, flush at cycle 0:
  - 9 COPY cycles; last group idx 32,33,34 with frat_wr_en = 4'b0111.
  - Cycle 10: fl_load = 1, fl_load_mask = {29{1}, 35{0}}, done = 1.
  - busy high in cycles 1..10.
- RRAT entry i = 63-i:
  - fl_load_mask bits 29..63 = 0 and bits 0..28 = 1.
  - frat_wr_data matches per lane in every COPY cycle.
- Second flush_req in COPY cycle 5:
  - Next cycle restarts at idx 0..3; busy stays high continuously.
  - Exactly one fl_load and one done, at cycle 15.
- RESET asserted in COPY cycle 3: next cycle busy = 0, frat_wr_en = 0, no fl_load; a subsequent flush performs a full 10-cycle recovery.
- LANES = 1 and LANES = 35 builds:
  - LANES = 1: done after 36 cycles.
  - LANES = 35: one COPY cycle with all enables set, done at cycle 2.
- With RAT_RECOVERY_PERF_EN: two recoveries give perf_flushes = 2 and perf_stall_cycles = 20. Without the macro both read 0.

Source files
------------

// File: rtl/rat_recovery_sequencer_pkg.sv
// Shared widths, defaults and FSM encoding for the RAT recovery sequencer.
// Optional perf counters are enabled in the top with RAT_RECOVERY_PERF_EN.
package rat_recovery_sequencer_pkg;

  localparam int NUM_ARCH_REGS_DEF = 35;
  localparam int NUM_PHYS_REGS_DEF = 64;
  localparam int LANES_DEF         = 4;

  // Width helper that never collapses to zero bits for single-entry tables.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  localparam int LOG_PHYS = clog2_min1(NUM_PHYS_REGS_DEF);
  localparam int LOG_ARCH = clog2_min1(NUM_ARCH_REGS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_LOAD = 2'd2
  } rec_state_t;

endpackage

// File: rtl/rat_recovery_sequencer_used_mask.sv
// Accumulates the set of physical registers named by the committed RRAT mappings.
// The mask is a plain OR of per-lane one-hot tags; duplicates are not detected.
module recovery_used_mask
  import rat_recovery_sequencer_pkg::*;
#(
  parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
  parameter int LANES         = LANES_DEF,
  parameter int TAG_W         = clog2_min1(NUM_PHYS_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     accumulate,
  input  logic [LANES-1:0]         lane_en,
  input  logic [LANES*TAG_W-1:0]   tags,
  output logic [NUM_PHYS_REGS-1:0] used
);

  logic [NUM_PHYS_REGS-1:0] set_bits;

  always_comb begin
    set_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        set_bits[tags[i*TAG_W +: TAG_W]] = 1'b1;
      end
    end
  end

  // Clear wins over accumulate so a restart never keeps stale bits.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      used <= '0;
    end else if (accumulate) begin
      used <= used | set_bits;
    end
  end

endmodule

// File: rtl/rat_recovery_sequencer.sv
// Walks the RRAT after a flush, copies it into the front-end RAT and reloads the free list.
// Define RAT_RECOVERY_PERF_EN to build the flush and stall-cycle counters.
module rat_recovery_sequencer
  import rat_recovery_sequencer_pkg::*;
#(
  parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
  parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
  parameter int LANES         = LANES_DEF,
  parameter int LOG_PHYS_W    = clog2_min1(NUM_PHYS_REGS),
  parameter int LOG_ARCH_W    = clog2_min1(NUM_ARCH_REGS)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          flush_req,
  output logic [LANES*LOG_ARCH_W-1:0]   rrat_rd_idx,
  input  logic [LANES*LOG_PHYS_W-1:0]   rrat_rd_data,
  output logic [LANES-1:0]              frat_wr_en,
  output logic [LANES*LOG_ARCH_W-1:0]   frat_wr_idx,
  output logic [LANES*LOG_PHYS_W-1:0]   frat_wr_data,
  output logic                          fl_load,
  output logic [NUM_PHYS_REGS-1:0]      fl_load_mask,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   perf_flushes,
  output logic [31:0]                   perf_stall_cycles,
  output logic [1:0]                    dbg_state
);

  // Wide enough to hold base+LANES without wrapping.
  localparam int BASE_W = clog2_min1(NUM_ARCH_REGS + LANES);

  // Handshake: flush_req is a one-cycle pulse sampled at the edge; busy high
  // means the RRAT must stay frozen and rename/retire must hold; done and
  // fl_load are single-cycle pulses in the LOAD cycle.

  rec_state_t               state_q;
  rec_state_t               next_state;
  logic [BASE_W-1:0]        base_q;
  logic [BASE_W-1:0]        lane_idx [LANES];
  logic [LANES-1:0]         lane_live;
  logic [NUM_PHYS_REGS-1:0] used_q;
  logic                     last_group;

  assign dbg_state  = state_q;
  assign last_group = (base_q + BASE_W'(LANES)) >= BASE_W'(NUM_ARCH_REGS);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  always_comb begin
    next_state = state_q;
    if (flush_req) begin
      next_state = ST_COPY;
    end else begin
      case (state_q)
        ST_IDLE: next_state = ST_IDLE;
        ST_COPY: next_state = last_group ? ST_LOAD : ST_COPY;
        ST_LOAD: next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || flush_req) begin
      base_q <= '0;
    end else if (state_q == ST_COPY) begin
      base_q <= base_q + BASE_W'(LANES);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_idx[i]  = base_q + BASE_W'(i);
      lane_live[i] = (state_q == ST_COPY) && (lane_idx[i] < BASE_W'(NUM_ARCH_REGS));
    end
  end

  recovery_used_mask #(
    .NUM_PHYS_REGS (NUM_PHYS_REGS),
    .LANES         (LANES),
    .TAG_W         (LOG_PHYS_W)
  ) u_used_mask (
    .clk        (CLK),
    .reset      (RESET),
    .clear      (flush_req),
    .accumulate (state_q == ST_COPY),
    .lane_en    (lane_live),
    .tags       (rrat_rd_data),
    .used       (used_q)
  );

  always_comb begin
    rrat_rd_idx  = '0;
    frat_wr_en   = '0;
    frat_wr_data = '0;
    fl_load      = 1'b0;
    fl_load_mask = '0;
    done         = 1'b0;
    busy         = (state_q != ST_IDLE);
    for (int i = 0; i < LANES; i++) begin
      if (lane_live[i]) begin
        rrat_rd_idx[i*LOG_ARCH_W +: LOG_ARCH_W]  = lane_idx[i][LOG_ARCH_W-1:0];
        frat_wr_en[i]                            = 1'b1;
        frat_wr_data[i*LOG_PHYS_W +: LOG_PHYS_W] = rrat_rd_data[i*LOG_PHYS_W +: LOG_PHYS_W];
      end
    end
    frat_wr_idx = rrat_rd_idx;
    // The aborted pass still reloads the free list if a flush lands on LOAD.
    if (state_q == ST_LOAD) begin
      fl_load      = 1'b1;
      fl_load_mask = ~used_q;
      done         = 1'b1;
    end
  end

`ifdef RAT_RECOVERY_PERF_EN
  logic [31:0] flush_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (flush_req) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (busy)      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_flushes      = flush_cnt_q;
  assign perf_stall_cycles = stall_cnt_q;
`else
  assign perf_flushes      = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule
